// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one single-port memory between the CPU MEM
// stage and a debug/loader port. It issues one fixed-latency access at a
// time, stalls the pipeline, and returns a one-cycle ack to debug.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no access in flight; arbitrate and latch the winner
// BUSY_CPU | CPU access in flight; latency counter running
// BUSY_DBG | debug access in flight; latency counter running
module dmem_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [31:0]   cpu_wdata_i,
  output logic [31:0]   cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [31:0]   dbg_wdata_i,
  output logic          dbg_ack_o,
  output logic [31:0]   dbg_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DBG} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   streak, streak_nxt;
  logic            grant_cpu, grant_dbg;
  logic            done;
  logic            en_q, we_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     cpu_rdata_q, dbg_rdata_q;
  logic            cpu_done, dbg_done;

  // The done cycle is the last busy cycle; a reset in that same cycle
  // abandons the access, so done is suppressed while rst_i is high.
  assign done     = (state != IDLE) && (cnt == '0) && !rst_i;
  assign cpu_done = done && (state == BUSY_CPU);
  assign dbg_done = done && (state == BUSY_DBG);

  assign cpu_stall_o = cpu_req_i && !rst_i && !cpu_done;
  assign dbg_ack_o   = dbg_done;
  assign cpu_rdata_o = (cpu_done && !we_q) ? mem_rdata_i : cpu_rdata_q;
  assign dbg_rdata_o = (dbg_done && !we_q) ? mem_rdata_i : dbg_rdata_q;

  assign mem_en_o    = en_q;
  assign mem_we_o    = we_q && en_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  // Arbitration, next state and starvation streak bookkeeping.
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    grant_cpu  = 1'b0;
    grant_dbg  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i && (!dbg_req_i || (streak != STREAK_MAX))) begin
          grant_cpu = 1'b1;
        end else if (dbg_req_i) begin
          grant_dbg = 1'b1;
        end

        if (grant_cpu) begin
          state_nxt = BUSY_CPU;
          if (!dbg_req_i) begin
            streak_nxt = '0;
          end else if (streak != STREAK_MAX) begin
            streak_nxt = streak + 1'b1;
          end
        end else if (grant_dbg) begin
          state_nxt  = BUSY_DBG;
          streak_nxt = '0;
        end else begin
          // No grant means debug is not requesting either.
          streak_nxt = '0;
        end
      end
      BUSY_CPU, BUSY_DBG: begin
        if (done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, latched transaction, latency down-counter and read holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      streak      <= '0;
      cnt         <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      en_q   <= grant_cpu || grant_dbg;

      if (grant_cpu) begin
        we_q    <= cpu_we_i;
        addr_q  <= cpu_addr_i;
        wdata_q <= cpu_wdata_i;
        cnt     <= CNT_LOAD;
      end else if (grant_dbg) begin
        we_q    <= dbg_we_i;
        addr_q  <= dbg_addr_i;
        wdata_q <= dbg_wdata_i;
        cnt     <= CNT_LOAD;
      end else if ((state != IDLE) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (cpu_done && !we_q) begin
        cpu_rdata_q <= mem_rdata_i;
      end
      if (dbg_done && !we_q) begin
        dbg_rdata_q <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: scoreboarded CPU/debug traffic on a
// MEM_LATENCY=2 instance plus a MEM_LATENCY=1 instance for back-to-back reads.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ack, mem_en, mem_we;

  logic        u1_req;
  logic [31:0] u1_addr;
  logic [31:0] u1_rdata, u1_dbg_rdata, u1_mem_addr, u1_mem_wdata, u1_mem_rdata;
  logic        u1_stall, u1_dbg_ack, u1_mem_en, u1_mem_we;
  logic        tie0;
  logic [31:0] tie32;

  int checks;
  int failures;
  logic [31:0] cpu_q[$];
  logic [31:0] dbg_q[$];
  logic [31:0] log_q[$];
  logic [31:0] mem [64];
  bit          written [64];
  logic [31:0] rd0;

  dmem_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4), .AW(32)) u0 (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_ack_o(dbg_ack), .dbg_rdata_o(dbg_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  dmem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4), .AW(32)) u1 (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(u1_req), .cpu_we_i(tie0), .cpu_addr_i(u1_addr),
    .cpu_wdata_i(tie32), .cpu_rdata_o(u1_rdata), .cpu_stall_o(u1_stall),
    .dbg_req_i(tie0), .dbg_we_i(tie0), .dbg_addr_i(tie32),
    .dbg_wdata_i(tie32), .dbg_ack_o(u1_dbg_ack), .dbg_rdata_o(u1_dbg_rdata),
    .mem_en_o(u1_mem_en), .mem_we_o(u1_mem_we), .mem_addr_o(u1_mem_addr),
    .mem_wdata_o(u1_mem_wdata), .mem_rdata_i(u1_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten words read as 0x1000+index, except word 0 which holds 5.
  function automatic logic [31:0] rdval(input logic [5:0] idx);
    if (written[idx]) return mem[idx];
    if (idx == 6'd0) return 32'd5;
    return 32'h1000 + {26'd0, idx};
  endfunction

  // Two-cycle memory model: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) begin
        mem[mem_addr[7:2]]     <= mem_wdata;
        written[mem_addr[7:2]] <= 1'b1;
      end
      rd0 <= rdval(mem_addr[7:2]);
    end
  end
  assign mem_rdata = rd0;

  // The latency-1 instance reads a fixed-content ROM combinationally.
  assign u1_mem_rdata = 32'h1000 + {26'd0, u1_mem_addr[7:2]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for completion", name);
  endtask

  // Monitor: pops the expected read-data value whenever a transaction completes.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_en === 1'b1) log_q.push_back(mem_addr);
      if (cpu_req && !cpu_stall) begin
        if (cpu_q.size() == 0) tmo("cpu_unexpected_completion");
        else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (dbg_ack === 1'b1) begin
        if (dbg_q.size() == 0) tmo("dbg_unexpected_ack");
        else chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp);
    bit ok;
    ok = 1'b0;
    cpu_q.push_back(exp);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!cpu_stall) begin ok = 1'b1; break; end
    end
    if (!ok) tmo("cpu_op");
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    dbg_q.push_back(exp);
    dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dbg_ack) begin ok = 1'b1; cyc = n; break; end
    end
    if (!ok) tmo("dbg_op");
    @(posedge clk); #1;
    dbg_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, cyc2;
    logic [31:0] exp_log [12];
    checks = 0; failures = 0;
    tie0 = 1'b0; tie32 = 32'd0;
    u1_req = 1'b0; u1_addr = 32'd0;

    // Reset with both requests pending: everything quiet.
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;  cpu_wdata = 32'd0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10; dbg_wdata = 32'd0;
    cpu_q.push_back(32'd5);
    dbg_q.push_back(32'h1004);
    repeat (2) begin
      @(negedge clk);
      chk1("rst_stall", cpu_stall, 1'b0);
      chk1("rst_ack", dbg_ack, 1'b0);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // CPU wins the first grant; read of address 0 with two-cycle latency.
    @(negedge clk);
    chk1("rd_stall_R", cpu_stall, 1'b1);
    chk1("rd_en_R", mem_en, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rd_stall_R1", cpu_stall, 1'b1);
    chk1("rd_en_R1", mem_en, 1'b1);
    chk1("rd_we_R1", mem_we, 1'b0);
    chk("rd_addr_R1", mem_addr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rd_stall_R2", cpu_stall, 1'b0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    cyc = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dbg_ack) begin cyc = 1; break; end
    end
    if (cyc == 0) tmo("dbg_after_reset");
    @(posedge clk); #1;
    dbg_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // CPU write 0x0C=7 alongside a debug read of 0x0C: debug acks at R+5.
    fork
      cpu_op(1'b1, 32'h0C, 32'd7, 32'd5);
      dbg_op(1'b0, 32'h0C, 32'd0, 32'd7, cyc);
    join
    chk("dbg_ack_latency", cyc, 32'd5);
    repeat (2) @(posedge clk);
    #1;

    // Starvation: ten CPU reads against two held debug requests.
    log_q.delete();
    fork
      begin
        for (int i = 0; i < 10; i++)
          cpu_op(1'b0, 32'h80 + 32'(4 * i), 32'd0, 32'h1020 + 32'(i));
      end
      begin
        dbg_op(1'b1, 32'h40, 32'hAB, 32'd7, cyc);
        dbg_op(1'b0, 32'h40, 32'd0, 32'hAB, cyc2);
      end
    join
    exp_log = '{32'h80, 32'h84, 32'h88, 32'h8C, 32'h40,
                32'h90, 32'h94, 32'h98, 32'h9C, 32'h40, 32'hA0, 32'hA4};
    chk("grant_count", 32'(log_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < log_q.size()) chk($sformatf("grant_order[%0d]", i), log_q[i], exp_log[i]);
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset in the debug done cycle: no ack, holds cleared, back to IDLE.
    dbg_we = 1'b0; dbg_addr = 32'h0C; dbg_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    dbg_req = 1'b0;
    @(negedge clk);
    chk1("mid_rst_ack_done_cycle", dbg_ack, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("mid_rst_ack", dbg_ack, 1'b0);
      chk1("mid_rst_en", mem_en, 1'b0);
      chk1("mid_rst_stall", cpu_stall, 1'b0);
      chk("mid_rst_dbg_rdata", dbg_rdata, 32'd0);
    end
    @(posedge clk); #1;
    cpu_op(1'b0, 32'h0, 32'd0, 32'd5);
    repeat (2) @(posedge clk);
    #1;

    // Latency 1: back-to-back reads, one stall cycle and one strobe per pair.
    u1_addr = 32'h20; u1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1($sformatf("l1_stall[%0d]", k), u1_stall, (k % 2) == 0);
      chk1($sformatf("l1_en[%0d]", k), u1_mem_en, (k % 2) == 1);
      if ((k % 2) == 1)
        chk($sformatf("l1_rdata[%0d]", k), u1_rdata, 32'h1008 + 32'(k / 2));
      @(posedge clk); #1;
      if ((k % 2) == 1) u1_addr = u1_addr + 32'd4;
      if (k == 5) u1_req = 1'b0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    chk("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the CPU MEM stage (EXMEM MemRead/MemWrite) and a debug/loader port that reads and writes memory while the CPU runs.
- Owns the memory sequencing: fixed-latency access timing, a stall to the pipeline, and an acknowledge handshake to debug.
- Sits between the EXMEM/MEMWB registers and Data_Memory. Its stall output is ORed into the hazard unit's stall/PCWrite logic.

Parameters:
MEM_LATENCY, 2, cycles from issue to read data valid (>=1)
STARVE_LIMIT, 4, consecutive CPU grants allowed while debug waits
AW, 32, address width (DW fixed 32)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cpu_req_i  in  1  CPU access request (MemRead|MemWrite); held stable while cpu_stall_o=1
cpu_we_i  in  1  1=write, 0=read
cpu_addr_i  in  AW  byte address
cpu_wdata_i  in  32  write data
cpu_rdata_o  out  32  read data to MEMWB
cpu_stall_o  out  1  freeze pipeline
dbg_req_i  in  1  debug request; held until dbg_ack_o
dbg_we_i  in  1  1=write
dbg_addr_i  in  AW  byte address
dbg_wdata_i  in  32  write data
dbg_ack_o  out  1  one-cycle completion pulse
dbg_rdata_o  out  32  debug read data
mem_en_o  out  1  one-cycle access strobe
mem_we_o  out  1  write enable, qualified by mem_en_o
mem_addr_o  out  AW  latched address
mem_wdata_o  out  32  latched write data
mem_rdata_i  in  32  memory read data, valid MEM_LATENCY-1 cycles after mem_en_o

Behaviour:
- FSM states: IDLE, BUSY_CPU, BUSY_DBG. Reset (rst_i=1 at posedge, any state): state=IDLE, all outputs 0, internal counters 0. An in-flight transaction is abandoned and no ack is issued.
- IDLE, cycle R:
  - No request: stay in IDLE.
  - Only one requester: grant it.
  - Both requesting: grant CPU unless streak==STARVE_LIMIT, in which case grant debug.
  - On grant, latch we/addr/wdata and go to BUSY_x.
- First BUSY cycle T=R+1: mem_en_o=1 with the latched mem_we_o/addr/wdata; mem_en_o=0 in every other cycle.
- Latency counter: done cycle D=R+MEM_LATENCY, when mem_rdata_i is valid. After D the FSM returns to IDLE, so a new grant is possible at D+1 and there is at least one IDLE cycle between transactions.
- cpu_stall_o = cpu_req_i & ~(state==BUSY_CPU & done). The CPU is stalled in R..D-1 and released in D.
  - MEM_LATENCY=1: stalled in R only.
  - While a debug transaction is in progress, a CPU request stalls for that transaction and then for its own.
- cpu_rdata_o: equals mem_rdata_i in a CPU read done cycle; otherwise it holds the last CPU read value. CPU writes do not change it.
- dbg_ack_o=1 only in the debug done cycle. dbg_rdata_o follows the same rule as cpu_rdata_o, applied to debug reads.
- Starvation counter:
  - streak increments on each CPU grant made while dbg_req_i=1, saturating at STARVE_LIMIT.
  - Cleared on a debug grant, or on any IDLE cycle with dbg_req_i=0.
- Request dropped after grant: the latched transaction still completes and acks. Dropped before grant: nothing happens.
- Address is passed through unmodified (word indexing is done in Data_Memory). No address range checking.

Test Plan:
- Reset: hold rst_i 2 cycles with both requests high -> all outputs 0, no mem_en_o; release -> CPU is granted first.
- CPU read, MEM_LATENCY=2, addr 0x0, memory[0]=5: req at cycle R -> stall high in R and R+1; mem_en_o at R+1 with we=0; cpu_rdata_o=5 and stall low at R+2.
- CPU write 0x0C data 7, then debug read 0x0C -> debug ack at R+5, dbg_rdata_o=7.
- Starvation, STARVE_LIMIT=4: continuous CPU requests plus dbg_req held -> 4 CPU grants, then the debug grant; streak resets and CPU resumes.
- Mid-transaction reset: rst_i pulsed in BUSY_DBG -> no dbg_ack_o, state IDLE next cycle, cpu_stall_o=0.
- MEM_LATENCY=1: back-to-back CPU reads -> stall for 1 cycle per access, mem_en_o every 2 cycles.
